// File: rtl/collision_detector.sv
// Per-frame ball/target collision detector with a valid/ack report.
// Hits accumulate across a frame; the summary is published at the next start of frame.
package defines;
  localparam logic [7:0] COLOR_TRANSPARENT = 8'hFF;
endpackage

module collision_detector
  import defines::*;
#(
  parameter int NUM_TARGETS = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [7:0]               RGBBall,
  input  logic [NUM_TARGETS*8-1:0] RGBTargets,
  input  logic [10:0]              pixelX,
  input  logic [10:0]              pixelY,
  input  logic                     startOfFrame,
  input  logic                     collisionAck,
  output logic                     collisionValid,
  output logic [NUM_TARGETS-1:0]   collisionMask,
  output logic [10:0]              hitX,
  output logic [10:0]              hitY,
  output logic [7:0]               hitCount,
  output logic                     overrun
);

  typedef enum logic {
    WAIT_SOF,
    ACCUM
  } state_t;

  state_t                 state_q;
  logic [NUM_TARGETS-1:0] acc_mask_q;
  logic [10:0]            acc_x_q;
  logic [10:0]            acc_y_q;
  logic [7:0]             acc_cnt_q;
  logic                   valid_q;
  logic [NUM_TARGETS-1:0] mask_q;
  logic [10:0]            hit_x_q;
  logic [10:0]            hit_y_q;
  logic [7:0]             hit_cnt_q;
  logic                   ovr_q;

  logic                   ball_on;
  logic [NUM_TARGETS-1:0] hit;
  logic                   any_hit;
  logic                   accepted;
  logic                   publish;

  always_comb begin
    ball_on = (RGBBall != COLOR_TRANSPARENT);
    hit     = '0;
    for (int i = 0; i < NUM_TARGETS; i++) begin
      hit[i] = ball_on &&
        (RGBTargets[i*8 +: 8] != COLOR_TRANSPARENT);
    end
    any_hit  = |hit;
    accepted = valid_q && collisionAck;
    publish  = (state_q == ACCUM) && startOfFrame
               && (acc_mask_q != '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= WAIT_SOF;
      acc_mask_q <= '0;
      acc_x_q    <= '0;
      acc_y_q    <= '0;
      acc_cnt_q  <= '0;
      valid_q    <= 1'b0;
      mask_q     <= '0;
      hit_x_q    <= '0;
      hit_y_q    <= '0;
      hit_cnt_q  <= '0;
      ovr_q      <= 1'b0;
    end else begin
      if (publish) begin
        mask_q    <= acc_mask_q;
        hit_x_q   <= acc_x_q;
        hit_y_q   <= acc_y_q;
        hit_cnt_q <= acc_cnt_q;
        valid_q   <= 1'b1;
        if (valid_q && !collisionAck) ovr_q <= 1'b1;
      end else if (accepted) begin
        valid_q <= 1'b0;
      end

      // The start-of-frame pixel already belongs to the new frame
      if (startOfFrame) begin
        state_q    <= ACCUM;
        acc_mask_q <= hit;
        acc_cnt_q  <= {7'd0, any_hit};
        if (any_hit) begin
          acc_x_q <= pixelX;
          acc_y_q <= pixelY;
        end
      end else if (state_q == ACCUM && any_hit) begin
        acc_mask_q <= acc_mask_q | hit;
        if (acc_cnt_q != 8'hFF) acc_cnt_q <= acc_cnt_q + 8'd1;
        if (acc_mask_q == '0) begin
          acc_x_q <= pixelX;
          acc_y_q <= pixelY;
        end
      end
    end
  end

  assign collisionValid = valid_q;
  assign collisionMask  = mask_q;
  assign hitX           = hit_x_q;
  assign hitY           = hit_y_q;
  assign hitCount       = hit_cnt_q;
  assign overrun        = ovr_q;

endmodule

// File: tb/tb_collision_detector.sv
// Random and directed stimulus for collision_detector,
// checked every cycle against a frame-level reference model.
module tb_collision_detector;
  import defines::*;

  localparam int NT = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    RGBBall;
  logic [NT*8-1:0] RGBTargets;
  logic [10:0]   pixelX;
  logic [10:0]   pixelY;
  logic          startOfFrame;
  logic          collisionAck;
  logic          collisionValid;
  logic [NT-1:0] collisionMask;
  logic [10:0]   hitX;
  logic [10:0]   hitY;
  logic [7:0]    hitCount;
  logic          overrun;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  bit          m_started;
  bit [NT-1:0] m_fmask;
  int          m_fcnt;
  int          m_fx, m_fy;
  bit          m_valid, m_ovr;
  int          m_mask, m_x, m_y, m_cnt;

  collision_detector #(.NUM_TARGETS(NT)) dut (
    .clk(clk),
    .reset(reset),
    .RGBBall(RGBBall),
    .RGBTargets(RGBTargets),
    .pixelX(pixelX),
    .pixelY(pixelY),
    .startOfFrame(startOfFrame),
    .collisionAck(collisionAck),
    .collisionValid(collisionValid),
    .collisionMask(collisionMask),
    .hitX(hitX),
    .hitY(hitY),
    .hitCount(hitCount),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rand_color();
    return 8'($urandom_range(0, 254));
  endfunction

  // Drive one pixel: ball drawn or not, and which targets are drawn
  task automatic set_pix(input bit ball, input bit [NT-1:0] tdraw,
                         input int x, input int y);
    RGBBall = ball ? rand_color() : COLOR_TRANSPARENT;
    for (int i = 0; i < NT; i++)
      RGBTargets[i*8 +: 8] = tdraw[i] ? rand_color() : COLOR_TRANSPARENT;
    pixelX = 11'(x);
    pixelY = 11'(y);
  endtask

  task automatic model_update();
    bit [NT-1:0] h;
    h = '0;
    for (int i = 0; i < NT; i++)
      h[i] = (RGBBall != COLOR_TRANSPARENT) &&
             (RGBTargets[i*8 +: 8] != COLOR_TRANSPARENT);
    if (reset) begin
      m_started = 0; m_fmask = '0; m_fcnt = 0;
      m_valid = 0; m_ovr = 0;
      m_mask = 0; m_x = 0; m_y = 0; m_cnt = 0;
      return;
    end
    if (startOfFrame) begin
      if (m_started && m_fmask != 0) begin
        if (m_valid && !collisionAck) m_ovr = 1;
        m_valid = 1;
        m_mask  = int'(m_fmask);
        m_x = m_fx; m_y = m_fy;
        m_cnt = (m_fcnt > 255) ? 255 : m_fcnt;
      end else if (m_valid && collisionAck) begin
        m_valid = 0;
      end
      m_started = 1;
      m_fmask = h;
      m_fcnt = (h != 0) ? 1 : 0;
      if (h != 0) begin
        m_fx = int'(pixelX); m_fy = int'(pixelY);
      end
    end else begin
      if (m_valid && collisionAck) m_valid = 0;
      if (m_started && h != 0) begin
        if (m_fmask == 0) begin
          m_fx = int'(pixelX); m_fy = int'(pixelY);
        end
        m_fmask |= h;
        m_fcnt++;
      end
    end
  endtask

  task automatic compare_all();
    check("valid", int'(collisionValid), int'(m_valid));
    check("mask", int'(collisionMask), m_mask);
    check("hitX", int'(hitX), m_x);
    check("hitY", int'(hitY), m_y);
    check("hitCount", int'(hitCount), m_cnt);
    check("overrun", int'(overrun), int'(m_ovr));
  endtask

  // One clock: inputs already set; model advances; outputs compared after edge
  task automatic step(input bit rst, input bit sof, input bit ack);
    reset = rst;
    startOfFrame = sof;
    collisionAck = ack;
    @(posedge clk);
    model_update();
    #1;
    compare_all();
  endtask

  task automatic blank(input int n);
    for (int i = 0; i < n; i++) begin
      set_pix(0, '0, i, 0);
      step(0, 0, 0);
    end
  endtask

  initial begin
    reset = 1; startOfFrame = 0; collisionAck = 0;
    set_pix(0, '0, 0, 0);
    step(1, 0, 0);
    step(1, 0, 0);

    // hits before first frame are ignored; empty frame gives no report
    for (int i = 0; i < 5; i++) begin
      set_pix(1, 4'b1111, i, 1);
      step(0, 0, 0);
    end
    set_pix(0, '0, 0, 0);
    step(0, 1, 0);
    blank(4);
    step(0, 1, 0);
    check("empty_valid", int'(collisionValid), 0);

    // ball over target 2 at (100,50),(101,50)
    set_pix(1, 4'b0100, 100, 50); step(0, 0, 0);
    set_pix(1, 4'b0100, 101, 50); step(0, 0, 0);
    blank(3);
    step(0, 1, 0);
    check("t2_valid", int'(collisionValid), 1);
    check("t2_mask", int'(collisionMask), 4);
    check("t2_x", int'(hitX), 100);
    check("t2_y", int'(hitY), 50);
    check("t2_cnt", int'(hitCount), 2);
    blank(2);
    step(0, 0, 1);
    check("ack_valid", int'(collisionValid), 0);
    check("ack_mask", int'(collisionMask), 4);

    // unacked report overwritten by a target 0 frame
    set_pix(1, 4'b0001, 7, 8); step(0, 0, 0);
    set_pix(0, '0, 0, 0); step(0, 1, 0);
    set_pix(1, 4'b0001, 9, 9); step(0, 0, 0);
    set_pix(0, '0, 0, 0); step(0, 1, 0);
    check("ovr_mask", int'(collisionMask), 1);
    check("ovr_flag", int'(overrun), 1);

    // fresh reset, then same scenario with ack in the sof cycle
    step(1, 0, 0);
    step(0, 1, 0);
    set_pix(1, 4'b0001, 3, 3); step(0, 0, 0);
    set_pix(0, '0, 0, 0); step(0, 1, 0);
    set_pix(1, 4'b0001, 4, 4); step(0, 0, 0);
    set_pix(0, '0, 0, 0); step(0, 1, 1);
    check("ackovr_flag", int'(overrun), 0);
    check("ackovr_valid", int'(collisionValid), 1);

    // saturation
    for (int i = 0; i < 300; i++) begin
      set_pix(1, 4'b1000, i, 200); step(0, 0, 0);
    end
    set_pix(0, '0, 0, 0); step(0, 1, 1);
    check("sat_cnt", int'(hitCount), 255);

    // transparent ball over drawn target
    step(0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      set_pix(0, 4'b1111, i, 5); step(0, 0, 0);
    end
    step(0, 1, 0);
    check("transp_valid", int'(collisionValid), 0);

    // reset mid-frame with pending report
    set_pix(1, 4'b0010, 20, 21); step(0, 0, 0);
    set_pix(0, '0, 0, 0); step(0, 1, 0);
    set_pix(1, 4'b0010, 22, 21); step(0, 0, 0);
    step(1, 0, 0);
    check("rst_valid", int'(collisionValid), 0);
    check("rst_mask", int'(collisionMask), 0);
    check("rst_cnt", int'(hitCount), 0);

    // randomized frames
    for (int f = 0; f < 60; f++) begin
      int len;
      len = $urandom_range(1, 60);
      for (int p = 0; p < len; p++) begin
        bit rst;
        rst = ($urandom_range(0, 299) == 0);
        set_pix($urandom_range(0, 1) == 1, NT'($urandom),
                $urandom_range(0, 2047), $urandom_range(0, 2047));
        step(rst, p == 0, $urandom_range(0, 7) == 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
